// File: rtl/regs_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regs_ctrl_if
// Description : Instruction, register-file and result buses of regs_ctrl.
// Revision    : 1.0
// ============================================================================
interface regs_ctrl_if #(
    parameter int DATASIZE = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_instr;
    logic [4:0]          in_data;
    logic                rf_en;
    logic [7:0]          rf_instr;
    logic [4:0]          rf_data;
    logic [DATASIZE-1:0] rf_a;
    logic [DATASIZE-1:0] rf_b;
    logic                res_valid;
    logic                res_ready;
    logic [DATASIZE-1:0] res_a;
    logic [DATASIZE-1:0] res_b;
    logic                err;
    logic [7:0]          ops_cnt;

    modport master (
        output in_valid, in_instr, in_data, rf_a, rf_b, res_ready,
        input  in_ready, rf_en, rf_instr, rf_data, res_valid, res_a, res_b,
               err, ops_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_data, rf_a, rf_b, res_ready,
        output in_ready, rf_en, rf_instr, rf_data, res_valid, res_a, res_b,
               err, ops_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regs_ctrl
// Description : Single-outstanding instruction controller for a register file.
//               Define REGS_CTRL_ILLEGAL_FILTER_EN to drop illegal opcodes
//               with an err pulse instead of issuing them.
// Revision    : 1.0
// ============================================================================
module regs_ctrl #(
    parameter int DATASIZE = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regs_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_READ  = 3'd0;
    localparam logic [2:0] c_OP_WRITE = 3'd6;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_instr;
    logic [4:0]          r_data;
    logic [DATASIZE-1:0] r_res_a;
    logic [DATASIZE-1:0] r_res_b;
    logic [7:0]          r_ops_cnt;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_drop;
    logic                w_take;

    // in_ready is gated by rst so it is low throughout reset, high right after.
    assign w_in_ready = (r_state == IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_take     = w_accept && !w_drop;

`ifdef REGS_CTRL_ILLEGAL_FILTER_EN
    logic w_legal;
    logic r_err;

    assign w_legal = (bus.in_instr[7:5] == c_OP_READ) || (bus.in_instr[7:5] == c_OP_WRITE);
    assign w_drop  = w_accept && !w_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_drop;
        end
    end

    assign bus.err = r_err;
`else
    assign w_drop  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_next = ISSUE;
            ISSUE:   w_state_next = (r_instr[7:5] == c_OP_READ) ? WAIT : IDLE;
            WAIT:    w_state_next = RESP;
            RESP:    if (bus.res_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr   <= 8'd0;
            r_data    <= 5'd0;
            r_res_a   <= '0;
            r_res_b   <= '0;
            r_ops_cnt <= 8'd0;
        end else begin
            if (w_take) begin
                r_instr <= bus.in_instr;
                r_data  <= bus.in_data;
            end
            if (r_state == WAIT) begin
                r_res_a <= bus.rf_a;
                r_res_b <= bus.rf_b;
            end
            if (r_state == ISSUE) begin
                r_ops_cnt <= r_ops_cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rf_en     = (r_state == ISSUE);
    assign bus.rf_instr  = r_instr;
    assign bus.rf_data   = r_data;
    assign bus.res_valid = (r_state == RESP);
    assign bus.res_a     = r_res_a;
    assign bus.res_b     = r_res_b;
    assign bus.ops_cnt   = r_ops_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regs_ctrl
// Description : Directed self-checking bench for regs_ctrl with a two-entry
//               register-file model and a result scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_regs_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_ops = 8'd0;
    logic [2*DW-1:0] sb_q[$];
    logic [2*DW-1:0] exp_res;
    logic [DW-1:0] regs [2];

    regs_ctrl_if #(.DATASIZE(DW)) bus ();

    regs_ctrl #(.DATASIZE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: opcode 6 writes data[3:0] into reg[data[4]];
    // read select [4] enables port A from reg0, [3] enables port B from reg1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            regs[0] <= '0;
            regs[1] <= '0;
        end else if (bus.rf_en && bus.rf_instr[7:5] == 3'd6) begin
            regs[bus.rf_data[4]] <= {4'b0, bus.rf_data[3:0]};
        end
    end
    assign bus.rf_a = bus.rf_instr[4] ? regs[0] : '0;
    assign bus.rf_b = bus.rf_instr[3] ? regs[1] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and returns 1 ns after its acceptance edge.
    task automatic send(input logic [7:0] instr, input logic [4:0] data);
        int waited = 0;
        bus.in_instr = instr;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready observed 0 expected 1");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_and_check(input string tag);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard observed empty expected an entry", tag);
            exp_res = '0;
        end else begin
            exp_res = sb_q.pop_front();
        end
        check({tag, "_a"}, {24'd0, bus.res_a}, {24'd0, exp_res[2*DW-1:DW]});
        check({tag, "_b"}, {24'd0, bus.res_b}, {24'd0, exp_res[DW-1:0]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation observed no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 8'd0;
        bus.in_data   = 5'd0;
        bus.res_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_rf_en", {31'd0, bus.rf_en}, 32'd0);
        check("rst_rf_instr", {24'd0, bus.rf_instr}, 32'd0);
        check("rst_rf_data", {27'd0, bus.rf_data}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_a", {24'd0, bus.res_a}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ops_cnt", {24'd0, bus.ops_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single write
        send(8'hC0, 5'h13);
        exp_ops++;
        check("wr_rf_en", {31'd0, bus.rf_en}, 32'd1);
        check("wr_rf_instr", {24'd0, bus.rf_instr}, 32'hC0);
        check("wr_rf_data", {27'd0, bus.rf_data}, 32'h13);
        check("wr_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("wr_rf_en_pulse", {31'd0, bus.rf_en}, 32'd0);
        check("wr_ops_cnt", {24'd0, bus.ops_cnt}, {24'd0, exp_ops});
        check("wr_no_res", {31'd0, bus.res_valid}, 32'd0);
        check("wr_back_idle", {31'd0, bus.in_ready}, 32'd1);

        // Two writes then a read with res_ready=1
        send(8'hC0, 5'h05); exp_ops++; tick();
        send(8'hC0, 5'h13); exp_ops++; tick();
        sb_q.push_back({8'h05, 8'h03});
        send(8'h18, 5'h02); exp_ops++;
        check("rd_rf_en", {31'd0, bus.rf_en}, 32'd1);
        tick();
        check("rd_wait_no_res", {31'd0, bus.res_valid}, 32'd0);
        tick();
        check("rd_res_valid", {31'd0, bus.res_valid}, 32'd1);
        pop_and_check("rd_res");
        tick();
        check("rd_res_one_cycle", {31'd0, bus.res_valid}, 32'd0);
        check("rd_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        check("rd_ops_cnt", {24'd0, bus.ops_cnt}, {24'd0, exp_ops});

        // Read with back-pressure, then a same-cycle offer on release
        bus.res_ready = 1'b0;
        sb_q.push_back({8'h05, 8'h03});
        send(8'h18, 5'h02); exp_ops++;
        tick();
        tick();
        pop_and_check("bp_res");
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
            check("bp_res_a", {24'd0, bus.res_a}, {24'd0, exp_res[2*DW-1:DW]});
            check("bp_res_b", {24'd0, bus.res_b}, {24'd0, exp_res[DW-1:0]});
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        bus.in_instr  = 8'hC0;
        bus.in_data   = 5'h05;
        bus.in_valid  = 1'b1;
        tick();
        check("bp_release_idle", {31'd0, bus.in_ready}, 32'd1);
        check("bp_release_no_res", {31'd0, bus.res_valid}, 32'd0);
        check("bp_no_early_accept", {31'd0, bus.rf_en}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        exp_ops++;
        check("bp_late_accept", {31'd0, bus.rf_en}, 32'd1);
        tick();
        check("bp_ops_cnt", {24'd0, bus.ops_cnt}, {24'd0, exp_ops});

        // Illegal opcode
        send(8'h20, 5'h00);
`ifdef REGS_CTRL_ILLEGAL_FILTER_EN
        check("ill_no_rf_en", {31'd0, bus.rf_en}, 32'd0);
        check("ill_err", {31'd0, bus.err}, 32'd1);
        check("ill_stay_idle", {31'd0, bus.in_ready}, 32'd1);
        check("ill_rf_instr_held", {24'd0, bus.rf_instr}, 32'hC0);
        tick();
        check("ill_err_pulse", {31'd0, bus.err}, 32'd0);
        check("ill_ops_cnt", {24'd0, bus.ops_cnt}, {24'd0, exp_ops});
`else
        exp_ops++;
        check("ill_rf_en", {31'd0, bus.rf_en}, 32'd1);
        check("ill_err_zero", {31'd0, bus.err}, 32'd0);
        check("ill_rf_instr", {24'd0, bus.rf_instr}, 32'h20);
        tick();
        check("ill_no_res", {31'd0, bus.res_valid}, 32'd0);
        check("ill_err_zero2", {31'd0, bus.err}, 32'd0);
        check("ill_ops_cnt", {24'd0, bus.ops_cnt}, {24'd0, exp_ops});
`endif
        check("ill_idle", {31'd0, bus.in_ready}, 32'd1);

        // Reset during WAIT abandons the read
        send(8'h18, 5'h02);
        tick();
        rst = 1'b1;
        #1;
        exp_ops = 8'd0;
        check("mid_rst_rf_en", {31'd0, bus.rf_en}, 32'd0);
        check("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid_rst_ops_cnt", {24'd0, bus.ops_cnt}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mid_rst_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("mid_rst_no_result", {31'd0, bus.res_valid}, 32'd0);
        check("mid_rst_res_a", {24'd0, bus.res_a}, 32'd0);

        // 256 back-to-back writes wrap ops_cnt
        for (int i = 0; i < 256; i++) begin
            send(8'hC0, 5'(i));
            exp_ops++;
            tick();
            if (i == 254) begin
                check("wrap_255", {24'd0, bus.ops_cnt}, 32'd255);
            end
        end
        check("wrap_model", {24'd0, exp_ops}, {24'd0, bus.ops_cnt});
        check("wrap_zero", {24'd0, bus.ops_cnt}, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
